// File: rtl/usb_data_recovery.sv
// Serial receive data-recovery buffer: input synchronizer, bit-wide elastic FIFO, prime/run read control.
// Optional NRZI decode at the read port when NRZI_DECODE_EN is defined.
module usb_data_recovery #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_480,
    input  logic reset,
    input  logic data_in,
    input  logic in_valid,
    input  logic out_ready,
    output logic data_out,
    output logic out_valid,
    output logic full,
    output logic empty,
    output logic overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {PRIME, RUN} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic [SYNC_STAGES-1:0] r_vld_sync;
    logic [DEPTH-1:0]       r_mem;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   r_data_out;
    logic                   r_out_valid;
    logic                   r_overflow;

    logic        w_din_sync;
    logic        w_vld_sync;
    logic        w_rd;
    logic        w_wr;
    logic        w_rd_bit;
    logic        w_dec_bit;
    logic [AW:0] w_count_next;

    assign w_din_sync = r_din_sync[SYNC_STAGES-1];
    assign w_vld_sync = r_vld_sync[SYNC_STAGES-1];

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);

    // A read frees a slot in the same edge, so a write at full is legal when paired with a read.
    assign w_rd     = (r_state == RUN) & out_ready & ~empty;
    assign w_wr     = w_vld_sync & (~full | w_rd);
    assign w_rd_bit = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        if (w_wr & ~w_rd)
            w_count_next = r_count + 1'b1;
        else if (~w_wr & w_rd)
            w_count_next = r_count - 1'b1;
    end

`ifdef NRZI_DECODE_EN
    logic r_ref;

    // No transition against the last read bit decodes as 1.
    assign w_dec_bit = ~(w_rd_bit ^ r_ref);

    always_ff @(posedge clock_480 or posedge reset) begin
        if (reset)
            r_ref <= 1'b1;
        else if (w_rd)
            r_ref <= w_rd_bit;
    end
`else
    assign w_dec_bit = w_rd_bit;
`endif

    always_ff @(posedge clock_480) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_din_sync;
    end

    always_ff @(posedge clock_480 or posedge reset) begin
        if (reset) begin
            r_din_sync  <= '0;
            r_vld_sync  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= 1'b0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_state     <= PRIME;
        end else begin
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], data_in};
            r_vld_sync  <= {r_vld_sync[SYNC_STAGES-2:0], in_valid};
            r_count     <= w_count_next;
            r_out_valid <= w_rd;
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= w_dec_bit;
            end
            if (w_vld_sync & full & ~w_rd)
                r_overflow <= 1'b1;
            case (r_state)
                PRIME:   if (w_count_next >= (AW+1)'(DEPTH/2)) r_state <= RUN;
                RUN:     if (w_count_next == '0)               r_state <= PRIME;
                default: r_state <= PRIME;
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_usb_data_recovery.sv
// Self-checking bench for usb_data_recovery against a queue-based reference model.
// NRZI_DECODE_EN, when defined, also enables the decode scenario.
module tb_usb_data_recovery;
    localparam int DEPTH = 16;
    localparam int SS    = 2;

    logic clk = 1'b0;
    logic reset, data_in, in_valid, out_ready;
    logic data_out, out_valid, full, empty, overflow;

    int checks   = 0;
    int failures = 0;

    usb_data_recovery #(.DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clock_480(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .out_ready(out_ready), .data_out(data_out), .out_valid(out_valid),
        .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: delay line for the synchronizer, a bit queue for storage.
    bit m_q[$];
    bit m_v[SS];
    bit m_d[SS];
    bit m_run, m_ovf, m_oval, m_dout, m_ref;

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < SS; i++) begin m_v[i] = 0; m_d[i] = 0; end
        m_run = 0; m_ovf = 0; m_oval = 0; m_dout = 0; m_ref = 1;
    endfunction

    function automatic void model_step(bit v, bit d, bit r);
        bit vs, ds, fl, rd, wr, b;
        vs = m_v[SS-1];
        ds = m_d[SS-1];
        fl = (m_q.size() == DEPTH);
        rd = m_run && r && (m_q.size() != 0);
        wr = vs && (!fl || rd);
        if (vs && fl && !rd) m_ovf = 1;
        m_oval = rd;
        if (rd) begin
            b = m_q.pop_front();
`ifdef NRZI_DECODE_EN
            m_dout = (b == m_ref);
`else
            m_dout = b;
`endif
            m_ref = b;
        end
        if (wr) m_q.push_back(ds);
        if (!m_run && m_q.size() >= DEPTH/2) m_run = 1;
        else if (m_run && m_q.size() == 0) m_run = 0;
        for (int i = SS-1; i > 0; i--) begin m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; end
        m_v[0] = v;
        m_d[0] = d;
    endfunction

    function automatic logic [4:0] mexp();
        return {m_oval, m_dout, m_q.size() == DEPTH, m_q.size() == 0, m_ovf};
    endfunction

    // Inputs are stable from posedge+1 until the next posedge; outputs sampled at posedge+1.
    task automatic tick();
        bit v, d, r;
        v = in_valid; d = data_in; r = out_ready;
        @(posedge clk);
        model_step(v, d, r);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; data_in = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, data_out, full, empty, overflow} !== 5'b00010) begin
            failures++;
            $display("FAIL reset_state got=%b exp=00010", {out_valid, data_out, full, empty, overflow});
        end
    endtask

    task automatic test_prime();
        int first = -1;
        int k = 0;
        do_reset();
        in_valid = 1; out_ready = 1;
        for (int n = 0; n < 3*DEPTH; n++) begin
            data_in = n[0];
            tick();
            checks++;
            if ({out_valid, data_out, full, empty, overflow} !== mexp()) begin
                failures++;
                $display("FAIL prime cyc=%0d got=%b exp=%b", n, {out_valid, data_out, full, empty, overflow}, mexp());
            end
            if (out_valid === 1'b1) begin
                if (first < 0) first = n;
                checks++;
                if (data_out !== k[0]) begin
                    failures++;
                    $display("FAIL prime_replay idx=%0d got=%b exp=%b", k, data_out, k[0]);
                end
                k++;
            end
        end
        checks++;
        if (first != SS + DEPTH/2) begin
            failures++;
            $display("FAIL prime_latency got=%0d exp=%0d", first, SS + DEPTH/2);
        end
    endtask

    task automatic test_fill_drain();
        int pulses = 0;
        bit seen = 0;
        do_reset();
        in_valid = 1; out_ready = 0; data_in = 1;
        for (int n = 0; n < DEPTH + SS + 2; n++) begin
            tick();
            checks++;
            if ({out_valid, data_out, full, empty, overflow} !== mexp()) begin
                failures++;
                $display("FAIL fill cyc=%0d got=%b exp=%b", n, {out_valid, data_out, full, empty, overflow}, mexp());
            end
        end
        checks++;
        if ({full, overflow} !== 2'b11) begin
            failures++;
            $display("FAIL fill_full_ovf got=%b exp=11", {full, overflow});
        end
        in_valid = 0;
        repeat (SS + 1) tick();
        out_ready = 1;
        for (int n = 0; n < DEPTH + 4; n++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
            checks++;
            if ({out_valid, data_out, full, empty, overflow} !== mexp()) begin
                failures++;
                $display("FAIL drain cyc=%0d got=%b exp=%b", n, {out_valid, data_out, full, empty, overflow}, mexp());
            end
        end
        checks++;
        if (pulses != DEPTH || empty !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL drain_count pulses=%0d empty=%b ovf=%b exp pulses=%0d empty=1 ovf=1", pulses, empty, overflow, DEPTH);
        end
        in_valid = 1;
        for (int n = 0; n < DEPTH/2 - 1; n++) begin
            data_in = $urandom_range(0, 1);
            tick();
            if (out_valid === 1'b1) seen = 1;
        end
        in_valid = 0;
        repeat (6) begin tick(); if (out_valid === 1'b1) seen = 1; end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reprime_7 got out_valid=1 exp=0");
        end
        in_valid = 1; data_in = 1;
        tick();
        in_valid = 0;
        repeat (6) begin tick(); if (out_valid === 1'b1) seen = 1; end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL reprime_8 got out_valid=0 exp=1");
        end
    endtask

    task automatic test_rw_full();
        do_reset();
        in_valid = 1; out_ready = 0;
        for (int n = 0; n < DEPTH + SS; n++) begin
            data_in = $urandom_range(0, 1);
            tick();
        end
        out_ready = 1;
        for (int n = 0; n < 40; n++) begin
            data_in = $urandom_range(0, 1);
            tick();
            checks++;
            if ({out_valid, data_out, full, empty, overflow} !== mexp() || full !== 1'b1 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL rw_full cyc=%0d got=%b exp=%b (full=1 ovf=0)", n, {out_valid, data_out, full, empty, overflow}, mexp());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1; out_ready = 1; data_in = 1;
        repeat (SS + DEPTH/2 + 3) tick();
        checks++;
        if ({out_valid, data_out} !== 2'b11) begin
            failures++;
            $display("FAIL areset_pre got=%b exp=11", {out_valid, data_out});
        end
        #2 reset = 1;
        #1;
        checks++;
        if ({out_valid, data_out, empty, full, overflow} !== 5'b00100) begin
            failures++;
            $display("FAIL areset_now got=%b exp=00100", {out_valid, data_out, empty, full, overflow});
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 99) < ((n / 150) % 2 ? 40 : 85));
            out_ready = ($urandom_range(0, 99) < ((n / 150) % 2 ? 90 : 45));
            data_in   = $urandom_range(0, 1);
            tick();
            checks++;
            if ({out_valid, data_out, full, empty, overflow} !== mexp()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", n, {out_valid, data_out, full, empty, overflow}, mexp());
            end
        end
    endtask

`ifdef NRZI_DECODE_EN
    task automatic test_nrzi();
        bit stim[8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        bit exp5[5] = '{1, 1, 0, 1, 0};
        bit got[$];
        do_reset();
        out_ready = 1;
        for (int n = 0; n < 8 + 20; n++) begin
            in_valid = (n < 8);
            data_in  = (n < 8) ? stim[n] : 1'b0;
            tick();
            if (out_valid === 1'b1) got.push_back(data_out);
            checks++;
            if ({out_valid, data_out, full, empty, overflow} !== mexp()) begin
                failures++;
                $display("FAIL nrzi cyc=%0d got=%b exp=%b", n, {out_valid, data_out, full, empty, overflow}, mexp());
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== exp5[i]) begin
                failures++;
                $display("FAIL nrzi_seq idx=%0d got=%b exp=%b", i, (got.size() > i) ? got[i] : 1'bx, exp5[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_prime();
        test_fill_drain();
        test_rw_full();
        test_async_reset();
        test_random();
`ifdef NRZI_DECODE_EN
        test_nrzi();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
